// File: rtl/spi_slave_mem.sv
// spi_slave_mem: SPI mode-0 slave backed by a byte RAM.
// Commands: 0x02 WRITE <addr> <data...>, 0x03 READ <addr> <dummy...>.
// Optional JEDEC ID command 0x9F is compiled in when SPI_SLV_JEDEC_EN is defined.
// SCK/NSS/MOSI are oversampled in the clk_i domain; clk_i must run >= 8x SCK.
module spi_slave_mem #(
    parameter int MEM_DEPTH   = 256,
    parameter int SYNC_STAGES = 2
`ifdef SPI_SLV_JEDEC_EN
    ,
    parameter logic [23:0] JEDEC_ID = 24'hEF4018
`endif
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic spi_sck_i,
    input  logic spi_nss_i,
    input  logic spi_mosi_i,
    output logic spi_miso_o,
    output logic spi_miso_en_o,
    output logic busy_o,
    output logic cmd_err_o
);

    localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_CMD    = 3'd1;
    localparam logic [2:0] ST_WADDR  = 3'd2;
    localparam logic [2:0] ST_WDATA  = 3'd3;
    localparam logic [2:0] ST_RADDR  = 3'd4;
    localparam logic [2:0] ST_RDATA  = 3'd5;
    localparam logic [2:0] ST_IGNORE = 3'd6;
`ifdef SPI_SLV_JEDEC_EN
    localparam logic [2:0] ST_JEDEC  = 3'd7;
`endif

    logic [SYNC_STAGES-1:0] sck_pipe;
    logic [SYNC_STAGES-1:0] nss_pipe;
    logic [SYNC_STAGES-1:0] mosi_pipe;
    logic                   sck;
    logic                   nss;
    logic                   mosi;
    logic                   sck_prev;
    logic                   nss_prev;
    logic                   sck_rise;
    logic                   sck_fall;
    logic                   nss_fall;

    logic [2:0]    state;
    logic [2:0]    bit_cnt;
    logic [6:0]    rx_sr;
    logic [7:0]    rx_byte;
    logic [7:0]    tx_sr;
    logic [AW-1:0] addr;
    logic          byte_done;
    logic          mem_we;
    logic          miso;
    logic          miso_en;
    logic          busy;
    logic          cmd_err;
`ifdef SPI_SLV_JEDEC_EN
    logic [1:0]    jedec_idx;
`endif

    logic [7:0] mem [0:MEM_DEPTH-1];

    // Bring the SPI pins into the clk_i domain; NSS idles high so a reset never looks like a select.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sck_pipe  <= '0;
            nss_pipe  <= '1;
            mosi_pipe <= '0;
            sck_prev  <= 1'b0;
            nss_prev  <= 1'b1;
        end else begin
            sck_pipe  <= {sck_pipe[SYNC_STAGES-2:0], spi_sck_i};
            nss_pipe  <= {nss_pipe[SYNC_STAGES-2:0], spi_nss_i};
            mosi_pipe <= {mosi_pipe[SYNC_STAGES-2:0], spi_mosi_i};
            sck_prev  <= sck;
            nss_prev  <= nss;
        end
    end

    assign sck      = sck_pipe[SYNC_STAGES-1];
    assign nss      = nss_pipe[SYNC_STAGES-1];
    assign mosi     = mosi_pipe[SYNC_STAGES-1];
    assign sck_rise = sck & ~sck_prev;
    assign sck_fall = ~sck & sck_prev;
    assign nss_fall = ~nss & nss_prev;

    assign rx_byte   = {rx_sr, mosi};
    assign byte_done = sck_rise && (bit_cnt == 3'd7) && !nss && (state != ST_IDLE);
    assign mem_we    = !rst_i && byte_done && (state == ST_WDATA);

    // Protocol FSM: bit counting on SCK rise, MISO shifting on SCK fall, command decode per byte.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= ST_IDLE;
            bit_cnt   <= 3'd0;
            rx_sr     <= 7'd0;
            tx_sr     <= 8'd0;
            addr      <= '0;
            miso      <= 1'b0;
            miso_en   <= 1'b0;
            busy      <= 1'b0;
            cmd_err   <= 1'b0;
`ifdef SPI_SLV_JEDEC_EN
            jedec_idx <= 2'd0;
`endif
        end else begin
            busy    <= ~nss;
            cmd_err <= 1'b0;
            if (nss) begin
                state   <= ST_IDLE;
                bit_cnt <= 3'd0;
                miso    <= 1'b0;
                miso_en <= 1'b0;
            end else if (state == ST_IDLE) begin
                if (nss_fall) begin
                    state   <= ST_CMD;
                    bit_cnt <= 3'd0;
                end
            end else begin
                if (sck_rise) begin
                    rx_sr   <= rx_byte[6:0];
                    bit_cnt <= bit_cnt + 3'd1;
                end
`ifdef SPI_SLV_JEDEC_EN
                if (sck_fall && (state == ST_RDATA || state == ST_JEDEC)) begin
`else
                if (sck_fall && (state == ST_RDATA)) begin
`endif
                    miso    <= tx_sr[7];
                    miso_en <= 1'b1;
                    tx_sr   <= {tx_sr[6:0], 1'b0};
                end
                if (byte_done) begin
                    case (state)
                        ST_CMD: begin
                            case (rx_byte)
                                8'h02: state <= ST_WADDR;
                                8'h03: state <= ST_RADDR;
`ifdef SPI_SLV_JEDEC_EN
                                8'h9F: begin
                                    state     <= ST_JEDEC;
                                    tx_sr     <= JEDEC_ID[23:16];
                                    jedec_idx <= 2'd1;
                                end
`endif
                                default: begin
                                    state   <= ST_IGNORE;
                                    cmd_err <= 1'b1;
                                end
                            endcase
                        end
                        ST_WADDR: begin
                            addr  <= rx_byte[AW-1:0];
                            state <= ST_WDATA;
                        end
                        ST_WDATA: begin
                            addr <= addr + AW'(1);
                        end
                        ST_RADDR: begin
                            addr  <= rx_byte[AW-1:0];
                            tx_sr <= mem[rx_byte[AW-1:0]];
                            state <= ST_RDATA;
                        end
                        ST_RDATA: begin
                            tx_sr <= mem[addr + AW'(1)];
                            addr  <= addr + AW'(1);
                        end
`ifdef SPI_SLV_JEDEC_EN
                        ST_JEDEC: begin
                            case (jedec_idx)
                                2'd1:    tx_sr <= JEDEC_ID[15:8];
                                2'd2:    tx_sr <= JEDEC_ID[7:0];
                                default: tx_sr <= 8'h00;
                            endcase
                            if (jedec_idx != 2'd3) begin
                                jedec_idx <= jedec_idx + 2'd1;
                            end
                        end
`endif
                        default: ;
                    endcase
                end
            end
        end
    end

    // Storage array; contents deliberately survive reset.
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem[addr] <= rx_byte;
        end
    end

    assign spi_miso_o    = miso;
    assign spi_miso_en_o = miso_en;
    assign busy_o        = busy;
    assign cmd_err_o     = cmd_err;

endmodule
